// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned radix-2 restoring divider.
// Responder for a start/ready/done handshake. Accepts a request on
// start && ready, produces one quotient bit per cycle, then pulses done
// for one cycle with quotient/remainder valid. Results hold until the
// next operation finishes.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   dividend   unsigned dividend, sampled on the accept edge
//   divisor    unsigned divisor, sampled on the accept edge
//   start      level request, may be held high
//   ready      high only while idle
//   quotient   registered quotient
//   remainder  registered remainder
//   done       single-cycle result-valid pulse (direct register output)
//
// Optional feature macro: SEQ_DIVIDER_ZERO_BYPASS_EN
//   When defined, a zero divisor skips the iterations and finishes one
//   cycle after the accept edge with quotient = all-ones and
//   remainder = dividend. Without it the iterations yield the same values.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             start,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // Partial remainder stays below the divisor after every step, so its
    // WIDTH+1-th bit is always zero between steps; only the shifted trial
    // value needs the extra bit.
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_ready;
    logic               r_done;

    logic               w_zero_div;
    logic [WIDTH:0]     w_shift_rem;
    logic [WIDTH:0]     w_trial;
    logic               w_trial_neg;
    logic [WIDTH-1:0]   w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;
    logic               w_last_step;
    logic               w_ready_nxt;
    logic               w_done_nxt;

`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
    assign w_zero_div = (divisor == '0);
`else
    assign w_zero_div = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, try subtracting.
    assign w_shift_rem = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_shift_rem - {1'b0, r_div};
    assign w_trial_neg = w_trial[WIDTH];
    assign w_rem_step  = w_trial_neg ? w_shift_rem[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_step  = {r_quo[WIDTH-2:0], ~w_trial_neg};
    assign w_last_step = (r_cnt == CNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_zero_div ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_last_step) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the upcoming state; registered below so ready/done
    // come straight from flops.
    always_comb begin
        w_ready_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            S_IDLE:  w_ready_nxt = 1'b1;
            S_DONE:  w_done_nxt  = 1'b1;
            default: begin
                w_ready_nxt = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_div <= divisor;
                        r_quo <= dividend;
                        r_rem <= '0;
                        r_cnt <= CNT_W'(WIDTH);
                        if (w_zero_div) begin
                            r_cnt       <= '0;
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                        end
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_step;
                    r_quo <= w_quo_step;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last_step) begin
                        r_quotient  <= w_quo_step;
                        r_remainder <= w_rem_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized and directed checks of seq_divider against
// an arithmetic reference (a / b, a % b, zero-divisor rules, latency).
module tb_seq_divider;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TMO   = 60;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             done;

    int unsigned      n_vec;
    int unsigned      n_err;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_r;

    seq_divider #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .dividend  (dividend),
        .divisor   (divisor),
        .start     (start),
        .ready     (ready),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned division with the zero-divisor convention.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                         output int unsigned lat);
        if (b == 0) begin
            q = '1;
            r = a;
`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
            lat = 1;
`else
            lat = WIDTH + 1;
`endif
        end else begin
            q = a / b;
            r = a % b;
            lat = WIDTH + 1;
        end
    endtask

    // Drive a request so that the next rising edge is the accept edge E0;
    // returns #1 after E0 with start still high.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        check("ready_before_accept", 64'(ready), 64'd1);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called just after E0. Finds the done pulse, checks latency, results,
    // handshake levels, and that outputs held until the result edge.
    task automatic wait_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] eq;
        logic [WIDTH-1:0] er;
        int unsigned      lat;
        int unsigned      found;
        model(a, b, eq, er, lat);
        found = 0;
        for (int k = 1; k <= int'(TMO); k++) begin
            @(negedge clk);
            if (k == 1 && lat > 1) begin
                check("ready_low_busy", 64'(ready), 64'd0);
                check("q_hold_busy", 64'(quotient), 64'(prev_q));
                check("r_hold_busy", 64'(remainder), 64'(prev_r));
            end
            if (done) begin
                found = k;
                break;
            end
        end
        check("done_latency", 64'(found), 64'(lat));
        check("quotient", 64'(quotient), 64'(eq));
        check("remainder", 64'(remainder), 64'(er));
        check("ready_low_done", 64'(ready), 64'd0);
        prev_q = eq;
        prev_r = er;
        @(negedge clk);
        check("done_single", 64'(done), 64'd0);
        check("ready_after_done", 64'(ready), 64'd1);
    endtask

    task automatic run_plain(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start_op(a, b);
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        wait_result(a, b);
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] a2;
        logic [WIDTH-1:0] b2;
        int unsigned      sel;

        n_vec    = 0;
        n_err    = 0;
        prev_q   = '0;
        prev_r   = '0;
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);

        // Directed cases.
        run_plain(32'd100, 32'd7);
        run_plain(32'hFFFF_FFFF, 32'd1);
        run_plain(32'd5, 32'hFFFF_FFFF);
        run_plain(32'h1234, 32'd0);
        run_plain(32'd0, 32'd9);

        // Held start with operands changed during BUSY: back-to-back ops.
        a  = 32'd1000;
        b  = 32'd33;
        a2 = $urandom;
        b2 = $urandom | 32'd1;
        start_op(a, b);
        dividend = a2;
        divisor  = b2;
        wait_result(a, b);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        wait_result(a2, b2);

        // Reset mid-operation, with start already high at the reset edge.
        start_op(32'd1000, 32'd7);
        start = 1'b0;
        repeat (9) begin
            @(negedge clk);
            check("no_done_before_abort", 64'(done), 64'd0);
        end
        dividend = 32'd20;
        divisor  = 32'd3;
        start    = 1'b1;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b1;
        prev_q = '0;
        prev_r = '0;
        @(negedge clk);
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        check("abort_q_cleared", 64'(quotient), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_result(32'd20, 32'd3);

        // Randomized operands with a mix of divisor magnitudes.
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 4);
            a   = (sel == 4) ? 32'($urandom_range(0, 100)) : 32'($urandom);
            case (sel)
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom;
                3:       b = a >> $urandom_range(0, 31);
                default: b = 32'($urandom_range(1, 200));
            endcase
            run_plain(a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
